// File: rtl/score_neighbor_fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | score_neighbor_fetch_if : request, score-RAM read and output bus   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface score_neighbor_fetch_if #(
   parameter int DATA_W = 9,
   parameter int IDX_W  = 4
);
   logic                 req_valid;
   logic                 req_ready;
   logic [IDX_W-1:0]     req_i;
   logic [IDX_W-1:0]     req_j;
   logic                 ram_rd_en;
   logic [2*IDX_W-1:0]   ram_rd_addr;
   logic [DATA_W-1:0]    ram_rd_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [DATA_W-1:0]    diag;
   logic [DATA_W-1:0]    left;
   logic [DATA_W-1:0]    up;
   logic [IDX_W-1:0]     out_i;
   logic [IDX_W-1:0]     out_j;
   logic                 err_req;

   modport master (
      input  req_valid, req_i, req_j, ram_rd_data, out_ready,
      output req_ready, ram_rd_en, ram_rd_addr, out_valid,
             diag, left, up, out_i, out_j, err_req
   );

   modport slave (
      output req_valid, req_i, req_j, ram_rd_data, out_ready,
      input  req_ready, ram_rd_en, ram_rd_addr, out_valid,
             diag, left, up, out_i, out_j, err_req
   );
endinterface
`default_nettype wire

// File: rtl/score_neighbor_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | score_neighbor_fetch : fetches diag/left/up scores for cell (i,j)  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module score_neighbor_fetch #(
   parameter int DATA_W = 9,
   parameter int IDX_W  = 4,
   parameter int RD_LAT = 1,
   parameter int GAP    = -2
) (
   input  logic                   clk,
   input  logic                   rst,
   score_neighbor_fetch_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [DATA_W-1:0] c_gap = DATA_W'(GAP);

   state_t                r_state;
   state_t                w_next;
   logic [IDX_W-1:0]      r_i;
   logic [IDX_W-1:0]      r_j;
   logic [DATA_W-1:0]     r_buf [3];
   logic [2:0]            r_pend;
   logic                  r_tag_v [RD_LAT];
   logic [1:0]            r_tag_s [RD_LAT];
   logic [DATA_W-1:0]     r_diag;
   logic [DATA_W-1:0]     r_left;
   logic [DATA_W-1:0]     r_up;
   logic [IDX_W-1:0]      r_oi;
   logic [IDX_W-1:0]      r_oj;
   logic                  r_err;

   logic [IDX_W-1:0]      w_qrow [3];
   logic [IDX_W-1:0]      w_qcol [3];
   logic [IDX_W-1:0]      w_row  [3];
   logic [IDX_W-1:0]      w_col  [3];
   logic [2:0]            w_qbnd;
   logic [DATA_W-1:0]     w_qpre [3];
   logic [DATA_W-1:0]     w_src  [3];
   logic                  w_accept;
   logic                  w_reject;
   logic                  w_start;
   logic [1:0]            w_slot;
   logic [2:0]            w_pend_next;
   logic                  w_cap;
   logic [1:0]            w_cap_s;
   logic                  w_busy;
   logic                  w_last;
   logic                  w_rd_en;
   logic [2*IDX_W-1:0]    w_rd_addr;

   // Boundary score GAP*index, wrapping in DATA_W bits; index is the nonzero coordinate.
   function automatic logic [DATA_W-1:0] f_bnd(input logic [IDX_W-1:0] row,
                                                input logic [IDX_W-1:0] col);
      logic [IDX_W-1:0] idx;
      idx = (row == '0) ? col : row;
      return DATA_W'(c_gap * DATA_W'(idx));
   endfunction

   always_comb begin
      // Slot order: diag(0)=(i-1,j-1), left(1)=(i,j-1), up(2)=(i-1,j)
      w_qrow[0] = bus.req_i - 1'b1;  w_qcol[0] = bus.req_j - 1'b1;
      w_qrow[1] = bus.req_i;         w_qcol[1] = bus.req_j - 1'b1;
      w_qrow[2] = bus.req_i - 1'b1;  w_qcol[2] = bus.req_j;
      w_row[0]  = r_i - 1'b1;        w_col[0]  = r_j - 1'b1;
      w_row[1]  = r_i;               w_col[1]  = r_j - 1'b1;
      w_row[2]  = r_i - 1'b1;        w_col[2]  = r_j;
      for (int s = 0; s < 3; s++) begin
         w_qbnd[s] = (w_qrow[s] == '0) || (w_qcol[s] == '0);
         w_qpre[s] = f_bnd(w_qrow[s], w_qcol[s]);
      end
   end

   assign w_accept = bus.req_valid && (r_state == IDLE);
   assign w_reject = w_accept && ((bus.req_i == '0) || (bus.req_j == '0));
   assign w_start  = w_accept && !w_reject;

   always_comb begin
      w_slot = r_pend[0] ? 2'd0 : (r_pend[1] ? 2'd1 : 2'd2);
      w_pend_next = r_pend & ~(3'b001 << w_slot);
      w_cap   = r_tag_v[RD_LAT-1];
      w_cap_s = r_tag_s[RD_LAT-1];
      w_busy  = 1'b0;
      for (int n = 0; n < RD_LAT-1; n++) begin
         w_busy = w_busy | r_tag_v[n];
      end
      w_last = (r_state == WAIT) && w_cap && !w_busy;
      // The final capture is folded straight into the output load.
      for (int s = 0; s < 3; s++) begin
         w_src[s] = (w_cap && (w_cap_s == 2'(s))) ? bus.ram_rd_data : r_buf[s];
      end
   end

   always_comb begin
      w_next    = r_state;
      w_rd_en   = 1'b0;
      w_rd_addr = '0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_next = (&w_qbnd) ? HOLD : ISSUE;
            end
         end
         ISSUE: begin
            w_rd_en = 1'b1;
            for (int s = 0; s < 3; s++) begin
               if (w_slot == 2'(s)) begin
                  w_rd_addr = {w_row[s], w_col[s]};
               end
            end
            if (w_pend_next == 3'b000) begin
               w_next = WAIT;
            end
         end
         WAIT: begin
            if (w_last) begin
               w_next = HOLD;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_i     <= '0;
         r_j     <= '0;
         r_pend  <= '0;
         r_diag  <= '0;
         r_left  <= '0;
         r_up    <= '0;
         r_oi    <= '0;
         r_oj    <= '0;
         r_err   <= 1'b0;
         for (int s = 0; s < 3; s++) begin
            r_buf[s] <= '0;
         end
         for (int n = 0; n < RD_LAT; n++) begin
            r_tag_v[n] <= 1'b0;
            r_tag_s[n] <= '0;
         end
      end else begin
         r_state <= w_next;
         r_err   <= w_reject;

         r_tag_v[0] <= w_rd_en;
         r_tag_s[0] <= w_slot;
         for (int n = 1; n < RD_LAT; n++) begin
            r_tag_v[n] <= r_tag_v[n-1];
            r_tag_s[n] <= r_tag_s[n-1];
         end

         for (int s = 0; s < 3; s++) begin
            if (w_cap && (w_cap_s == 2'(s))) begin
               r_buf[s] <= bus.ram_rd_data;
            end
         end

         if (w_start) begin
            r_i <= bus.req_i;
            r_j <= bus.req_j;
            for (int s = 0; s < 3; s++) begin
               r_buf[s]  <= w_qpre[s];
               r_pend[s] <= !w_qbnd[s];
            end
            if (&w_qbnd) begin
               r_diag <= w_qpre[0];
               r_left <= w_qpre[1];
               r_up   <= w_qpre[2];
               r_oi   <= bus.req_i;
               r_oj   <= bus.req_j;
            end
         end else if (r_state == ISSUE) begin
            r_pend <= w_pend_next;
         end

         if (w_last) begin
            r_diag <= w_src[0];
            r_left <= w_src[1];
            r_up   <= w_src[2];
            r_oi   <= r_i;
            r_oj   <= r_j;
         end
      end
   end

   assign bus.req_ready   = (r_state == IDLE);
   assign bus.ram_rd_en   = w_rd_en;
   assign bus.ram_rd_addr = w_rd_addr;
   assign bus.out_valid   = (r_state == HOLD);
   assign bus.diag        = r_diag;
   assign bus.left        = r_left;
   assign bus.up          = r_up;
   assign bus.out_i       = r_oi;
   assign bus.out_j       = r_oj;
   assign bus.err_req     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_score_neighbor_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_score_neighbor_fetch : directed bench, RD_LAT=1 and RD_LAT=2    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_score_neighbor_fetch;

   localparam int DATA_W = 9;
   localparam int IDX_W  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       out_ready;
   logic [3:0] req_i;
   logic [3:0] req_j;

   always #5 clk = ~clk;

   score_neighbor_fetch_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus0 ();
   score_neighbor_fetch_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus1 ();

   assign bus0.req_valid = req_valid;
   assign bus0.req_i     = req_i;
   assign bus0.req_j     = req_j;
   assign bus0.out_ready = out_ready;
   assign bus1.req_valid = req_valid;
   assign bus1.req_i     = req_i;
   assign bus1.req_j     = req_j;
   assign bus1.out_ready = out_ready;

   // RAM models: mem[a] = a, latency 1 for dut0, 2 for dut1
   logic [7:0] ram0_q;
   logic [7:0] ram1_q1;
   logic [7:0] ram1_q2;
   always_ff @(posedge clk) begin
      ram0_q  <= bus0.ram_rd_addr;
      ram1_q1 <= bus1.ram_rd_addr;
      ram1_q2 <= ram1_q1;
   end
   assign bus0.ram_rd_data = {1'b0, ram0_q};
   assign bus1.ram_rd_data = {1'b0, ram1_q2};

   score_neighbor_fetch #(.DATA_W(DATA_W), .IDX_W(IDX_W), .RD_LAT(1), .GAP(-2)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   score_neighbor_fetch #(.DATA_W(DATA_W), .IDX_W(IDX_W), .RD_LAT(2), .GAP(-2)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   int         rd_cnt  [2];
   int         rd_cyc  [2][4];
   int         rd_addr [2][4];
   int         ov_cyc  [2];
   int         ov_cnt  [2];
   int         err_cnt [2];
   logic [8:0] o_diag  [2];
   logic [8:0] o_left  [2];
   logic [8:0] o_up    [2];
   logic [3:0] o_i     [2];
   logic [3:0] o_j     [2];

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      for (int d = 0; d < 2; d++) begin
         rd_cnt[d] = 0; ov_cyc[d] = -1; ov_cnt[d] = 0; err_cnt[d] = 0;
         o_diag[d] = '0; o_left[d] = '0; o_up[d] = '0; o_i[d] = '0; o_j[d] = '0;
         for (int k = 0; k < 4; k++) begin
            rd_cyc[d][k] = -1; rd_addr[d][k] = -1;
         end
      end
   endtask

   task automatic rec(input int d, input int c, input logic en, input logic [7:0] a,
                      input logic ov, input logic [8:0] dg, input logic [8:0] lf,
                      input logic [8:0] upv, input logic [3:0] oi, input logic [3:0] oj,
                      input logic er);
      if (en) begin
         if (rd_cnt[d] < 4) begin
            rd_cyc[d][rd_cnt[d]]  = c;
            rd_addr[d][rd_cnt[d]] = int'(a);
         end
         rd_cnt[d]++;
      end
      if (ov) begin
         if (ov_cnt[d] == 0) begin
            ov_cyc[d] = c; o_diag[d] = dg; o_left[d] = lf; o_up[d] = upv;
            o_i[d] = oi; o_j[d] = oj;
         end
         ov_cnt[d]++;
      end
      if (er) err_cnt[d]++;
   endtask

   task automatic rec_both(input int c);
      rec(0, c, bus0.ram_rd_en, bus0.ram_rd_addr, bus0.out_valid, bus0.diag, bus0.left,
          bus0.up, bus0.out_i, bus0.out_j, bus0.err_req);
      rec(1, c, bus1.ram_rd_en, bus1.ram_rd_addr, bus1.out_valid, bus1.diag, bus1.left,
          bus1.up, bus1.out_i, bus1.out_j, bus1.err_req);
   endtask

   // Accept edge is cycle 0; cycles 1..ncyc are sampled on the falling edge.
   task automatic run_req(input logic [3:0] i, input logic [3:0] j, input int ncyc);
      clr();
      @(negedge clk);
      req_valid = 1'b1; req_i = i; req_j = j;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         rec_both(c);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int ovs;
      rst = 1'b1; req_valid = 1'b1; req_i = 4'd5; req_j = 4'd6; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", bus0.out_valid, 0);
      check("rst_rd_en",     bus0.ram_rd_en, 0);
      check("rst_rd_addr",   bus0.ram_rd_addr, 0);
      check("rst_err",       bus0.err_req, 0);
      check("rst_outs",      {bus0.diag, bus0.left, bus0.up, bus0.out_i, bus0.out_j}, 0);
      check("rst_req_ready", bus0.req_ready, 1);
      check("rst_d1_valid",  bus1.out_valid, 0);
      req_valid = 1'b0; rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("rel_req_ready", bus0.req_ready, 1);
      check("rel_out_valid", bus0.out_valid | bus1.out_valid, 0);

      // Interior cell (3,2)
      run_req(4'd3, 4'd2, 10);
      check("int_rd_cnt",  rd_cnt[0], 3);
      check("int_rd_cyc0", rd_cyc[0][0], 1);
      check("int_rd_cyc2", rd_cyc[0][2], 3);
      check("int_addr0",   rd_addr[0][0], 'h21);
      check("int_addr1",   rd_addr[0][1], 'h31);
      check("int_addr2",   rd_addr[0][2], 'h22);
      check("int_ov_cyc",  ov_cyc[0], 5);
      check("int_ov_cnt",  ov_cnt[0], 1);
      check("int_diag",    o_diag[0], 'h21);
      check("int_left",    o_left[0], 'h31);
      check("int_up",      o_up[0], 'h22);
      check("int_oi",      o_i[0], 3);
      check("int_oj",      o_j[0], 2);
      check("int_l2_ov_cyc", ov_cyc[1], 6);
      check("int_l2_left",   o_left[1], 'h31);

      // All-boundary cell (1,1)
      run_req(4'd1, 4'd1, 4);
      check("bnd_rd_cnt", rd_cnt[0] + rd_cnt[1], 0);
      check("bnd_ov_cyc", ov_cyc[0], 1);
      check("bnd_diag",   o_diag[0], 0);
      check("bnd_left",   o_left[0], 'h1FE);
      check("bnd_up",     o_up[0], 'h1FE);
      check("bnd_l2_ov_cyc", ov_cyc[1], 1);

      // Partial boundary (1,4)
      run_req(4'd1, 4'd4, 6);
      check("par_rd_cnt", rd_cnt[1], 1);
      check("par_addr",   rd_addr[1][0], 'h13);
      check("par_rd_cyc", rd_cyc[1][0], 1);
      check("par_ov_cyc", ov_cyc[1], 4);
      check("par_diag",   o_diag[1], 'h1FA);
      check("par_left",   o_left[1], 'h13);
      check("par_up",     o_up[1], 'h1F8);
      check("par_l1_ov_cyc", ov_cyc[0], 3);

      // Reject (0,3)
      run_req(4'd0, 4'd3, 5);
      check("rej_err_cnt",    err_cnt[0], 1);
      check("rej_l2_err_cnt", err_cnt[1], 1);
      check("rej_rd_cnt",     rd_cnt[0] + rd_cnt[1], 0);
      check("rej_ov_cnt",     ov_cnt[0] + ov_cnt[1], 0);

      // Backpressure: (2,2) with a pending (3,3) request held behind it
      out_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_i = 4'd2; req_j = 4'd2;
      @(posedge clk);
      #1 req_i = 4'd3; req_j = 4'd3;
      w = 0;
      while (!(bus0.out_valid && bus1.out_valid) && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("bp_wait_timeout", int'(w < 20), 1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_diag",  bus0.diag, 'h11);
         check("bp_left",  bus0.left, 'h21);
         check("bp_up",    bus1.up, 'h12);
         check("bp_valid", bus0.out_valid & bus1.out_valid, 1);
         check("bp_ready", bus0.req_ready | bus1.req_ready, 0);
         check("bp_rd_en", bus0.ram_rd_en | bus1.ram_rd_en, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_ready_after", bus0.req_ready & bus1.req_ready, 1);
      check("bp_valid_after", bus0.out_valid | bus1.out_valid, 0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      clr();
      @(negedge clk);
      check("bp_new_rd_en", bus0.ram_rd_en, 1);
      check("bp_new_addr",  bus0.ram_rd_addr, 'h22);
      for (int c = 2; c <= 10; c++) begin
         @(negedge clk);
         rec_both(c);
      end
      check("bp_new_diag", o_diag[0], 'h22);
      check("bp_new_left", o_left[0], 'h32);
      check("bp_new_up",   o_up[0], 'h23);
      check("bp_new_l2_up", o_up[1], 'h23);

      // Abort: (3,3) then reset while both instances are in WAIT
      @(negedge clk);
      req_valid = 1'b1; req_i = 4'd3; req_j = 4'd3;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abt_valid", bus0.out_valid | bus1.out_valid, 0);
      check("abt_rd_en", bus0.ram_rd_en | bus1.ram_rd_en, 0);
      check("abt_ready", bus0.req_ready & bus1.req_ready, 1);
      check("abt_outs",  {bus1.diag, bus1.left, bus1.up}, 0);
      @(negedge clk);
      rst = 1'b0;
      ovs = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         ovs += int'(bus0.out_valid) + int'(bus1.out_valid);
      end
      check("abt_no_valid", ovs, 0);
      run_req(4'd1, 4'd4, 6);
      check("abt_next_left", o_left[1], 'h13);
      check("abt_next_diag", o_diag[1], 'h1FA);
      check("abt_next_ov",   ov_cyc[1], 4);
      check("abt_next_l1",   o_left[0], 'h13);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
